// File: rtl/clint_ctrl.sv
// rtl/clint_ctrl.sv - core-local interrupt controller: trap entry/exit CSR write sequencer
module clint_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int CSR_AW     = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           inst_i,
   input  logic [31:0]           inst_addr_i,
   input  logic                  jump_flag_i,
   input  logic [31:0]           jump_addr_i,
   input  logic [7:0]            int_flag_i,
   input  logic                  global_int_en_i,
   input  logic [DATA_WIDTH-1:0] csr_mtvec_i,
   input  logic [DATA_WIDTH-1:0] csr_mepc_i,
   input  logic [DATA_WIDTH-1:0] csr_mstatus_i,
   output logic                  we_o,
   output logic [31:0]           waddr_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  hold_flag_o,
   output logic                  int_assert_o,
   output logic [DATA_WIDTH-1:0] int_addr_o
);

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;

   localparam logic [CSR_AW-1:0] CSR_MSTATUS = CSR_AW'(12'h300);
   localparam logic [CSR_AW-1:0] CSR_MEPC    = CSR_AW'(12'h341);
   localparam logic [CSR_AW-1:0] CSR_MCAUSE  = CSR_AW'(12'h342);

   localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL  = DATA_WIDTH'(32'd11);
   localparam logic [DATA_WIDTH-1:0] CAUSE_EBREAK = DATA_WIDTH'(32'd3);
   localparam logic [DATA_WIDTH-1:0] CAUSE_ASYNC  = DATA_WIDTH'(32'h8000_0007);

   // mstatus bit positions touched on trap entry and return
   localparam int MIE_BIT  = 3;
   localparam int MPIE_BIT = 7;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      W_MEPC    = 3'd1,
      W_MSTATUS = 3'd2,
      W_MCAUSE  = 3'd3,
      W_MRET    = 3'd4,
      ASSERT    = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] cause_q, cause_d;
   logic [DATA_WIDTH-1:0] epc_q, epc_d;
   logic                  mret_q, mret_d;

   logic                  ev_ecall, ev_ebreak, ev_mret, ev_async;
   logic [CSR_AW-1:0]     waddr_sel;

   // Event decode; nothing is detected while reset is held so outputs stay quiet
   always_comb begin
      ev_ecall  = rst_n && (inst_i == INST_ECALL);
      ev_ebreak = rst_n && (inst_i == INST_EBREAK);
      ev_mret   = rst_n && (inst_i == INST_MRET);
      ev_async  = rst_n && (int_flag_i != 8'h00) && global_int_en_i;
   end

   // Next-state, captured trap context and all outputs
   always_comb begin
      state_d      = state_q;
      cause_d      = cause_q;
      epc_d        = epc_q;
      mret_d       = mret_q;
      hold_flag_o  = 1'b0;
      we_o         = 1'b0;
      waddr_sel    = '0;
      data_o       = '0;
      int_assert_o = 1'b0;
      int_addr_o   = '0;

      case (state_q)
         IDLE: begin
            // Synchronous exceptions outrank MRET, which outranks async interrupts
            if (ev_ecall) begin
               hold_flag_o = 1'b1;
               cause_d     = CAUSE_ECALL;
               epc_d       = DATA_WIDTH'(inst_addr_i);
               mret_d      = 1'b0;
               state_d     = W_MEPC;
            end else if (ev_ebreak) begin
               hold_flag_o = 1'b1;
               cause_d     = CAUSE_EBREAK;
               epc_d       = DATA_WIDTH'(inst_addr_i);
               mret_d      = 1'b0;
               state_d     = W_MEPC;
            end else if (ev_mret) begin
               hold_flag_o = 1'b1;
               mret_d      = 1'b1;
               state_d     = W_MRET;
            end else if (ev_async) begin
               // A redirect in flight means inst_addr_i will never retire; resume at the target
               hold_flag_o = 1'b1;
               cause_d     = CAUSE_ASYNC;
               epc_d       = jump_flag_i ? DATA_WIDTH'(jump_addr_i) : DATA_WIDTH'(inst_addr_i);
               mret_d      = 1'b0;
               state_d     = W_MEPC;
            end
         end

         W_MEPC: begin
            hold_flag_o = 1'b1;
            we_o        = 1'b1;
            waddr_sel   = CSR_MEPC;
            data_o      = epc_q;
            state_d     = W_MSTATUS;
         end

         W_MSTATUS: begin
            // Save MIE into MPIE and disable interrupts for the handler
            hold_flag_o        = 1'b1;
            we_o               = 1'b1;
            waddr_sel          = CSR_MSTATUS;
            data_o             = csr_mstatus_i;
            data_o[MPIE_BIT]   = csr_mstatus_i[MIE_BIT];
            data_o[MIE_BIT]    = 1'b0;
            state_d            = W_MCAUSE;
         end

         W_MCAUSE: begin
            hold_flag_o = 1'b1;
            we_o        = 1'b1;
            waddr_sel   = CSR_MCAUSE;
            data_o      = cause_q;
            state_d     = ASSERT;
         end

         W_MRET: begin
            // Restore MIE from MPIE and set MPIE
            hold_flag_o        = 1'b1;
            we_o               = 1'b1;
            waddr_sel          = CSR_MSTATUS;
            data_o             = csr_mstatus_i;
            data_o[MIE_BIT]    = csr_mstatus_i[MPIE_BIT];
            data_o[MPIE_BIT]   = 1'b1;
            state_d            = ASSERT;
         end

         ASSERT: begin
            hold_flag_o  = 1'b1;
            int_assert_o = 1'b1;
            int_addr_o   = mret_q ? csr_mepc_i : csr_mtvec_i;
            state_d      = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      waddr_o = 32'(waddr_sel);
   end

   // State and trap-context registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cause_q <= '0;
         epc_q   <= '0;
         mret_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         epc_q   <= epc_d;
         mret_q  <= mret_d;
      end
   end

endmodule
